// File: rtl/bcd_display_driver.sv
// Two-digit multiplexed 7-segment driver with a load-triggered flash sequence.
// All display outputs are registered; the counters and FSM reset asynchronously.
`timescale 1ns/1ps
module bcd_display_driver #(
    parameter int unsigned REFRESH_DIV = 16,
    parameter int unsigned BLINK_TICKS = 4096,
    parameter int unsigned FLASH_COUNT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] bcd_in,
    input  logic       load,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [1:0] dig_en,
    output logic       busy
);

    localparam int unsigned RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned PW = $clog2(BLINK_TICKS + 1);
    localparam int unsigned CW = $clog2(FLASH_COUNT + 1);

    localparam logic [RW-1:0] R_LAST    = RW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] P_LAST    = PW'(BLINK_TICKS - 1);
    localparam logic [CW-1:0] PAIR_LAST = CW'(FLASH_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FLASH_DARK = 2'd1,
        FLASH_LIT  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [CW-1:0] pair_q, pair_d;
    logic          sel_q, sel_d;
    logic [7:0]    value_q, value_d;
    logic [6:0]    seg_q, seg_d;
    logic [1:0]    dig_q, dig_d;
    logic          busy_q, busy_d;

    logic          r_wrap;
    logic          phase_end;
    logic [3:0]    digit;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    // Refresh and value path run independently of the flash FSM.
    always_comb begin
        r_wrap  = (rcnt_q == R_LAST);
        rcnt_d  = r_wrap ? '0 : rcnt_q + RW'(1);
        sel_d   = r_wrap ? ~sel_q : sel_q;
        value_d = load ? bcd_in : value_q;
    end

    always_comb begin
        state_d   = state_q;
        pcnt_d    = pcnt_q;
        pair_d    = pair_q;
        phase_end = (pcnt_q == P_LAST);

        case (state_q)
            IDLE: begin
                pcnt_d = '0;
                pair_d = '0;
            end
            FLASH_DARK: begin
                if (phase_end) begin
                    pcnt_d  = '0;
                    state_d = FLASH_LIT;
                end else begin
                    pcnt_d = pcnt_q + PW'(1);
                end
            end
            FLASH_LIT: begin
                if (phase_end) begin
                    pcnt_d = '0;
                    if (pair_q == PAIR_LAST) begin
                        pair_d  = '0;
                        state_d = IDLE;
                    end else begin
                        pair_d  = pair_q + CW'(1);
                        state_d = FLASH_DARK;
                    end
                end else begin
                    pcnt_d = pcnt_q + PW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                pcnt_d  = '0;
                pair_d  = '0;
            end
        endcase

        // A load always (re)starts the sequence from the first dark phase.
        if (load) begin
            state_d = FLASH_DARK;
            pcnt_d  = '0;
            pair_d  = '0;
        end

        busy_d = (state_d != IDLE);
    end

    always_comb begin
        digit = sel_q ? value_q[7:4] : value_q[3:0];
        seg_d = decode(digit);
        dig_d = sel_q ? 2'b10 : 2'b01;
        if ((state_q == FLASH_DARK) ||
            (sel_q && blank_lz && (value_q[7:4] == 4'd0))) begin
            seg_d = '0;
            dig_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rcnt_q  <= '0;
            pcnt_q  <= '0;
            pair_q  <= '0;
            sel_q   <= 1'b0;
            value_q <= '0;
            seg_q   <= '0;
            dig_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            pcnt_q  <= pcnt_d;
            pair_q  <= pair_d;
            sel_q   <= sel_d;
            value_q <= value_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
            busy_q  <= busy_d;
        end
    end

    assign seg    = seg_q;
    assign dig_en = dig_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Randomized bench for bcd_display_driver against an arithmetic timeline model
// (edge count since reset, edge index of the last load).
`timescale 1ns/1ps
module tb_bcd_display_driver;

    localparam int unsigned RD    = 4;
    localparam int unsigned BT    = 8;
    localparam int unsigned FC    = 2;
    localparam int unsigned TOTAL = 2 * FC * BT;

    logic       clk;
    logic       rst_n;
    logic [7:0] bcd_in;
    logic       load;
    logic       blank_lz;
    logic [6:0] seg;
    logic [1:0] dig_en;
    logic       busy;

    int n_checks;
    int n_errors;

    // Model state: edges since reset release, last load edge, displayed value.
    int         m_k;
    int         m_load_k;
    bit         m_loaded;
    logic [7:0] m_val;
    logic [6:0] seg_tab [16];

    bcd_display_driver #(
        .REFRESH_DIV (RD),
        .BLINK_TICKS (BT),
        .FLASH_COUNT (FC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bcd_in   (bcd_in),
        .load     (load),
        .blank_lz (blank_lz),
        .seg      (seg),
        .dig_en   (dig_en),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at t=%0t k=%0d: got %02h expected %02h", tag, $time, m_k, obs, exp);
        end
    endtask

    function automatic bit model_dark();
        int d;
        d = m_k - m_load_k;
        return m_loaded && (d < int'(TOTAL)) && (((d / int'(BT)) % 2) == 0);
    endfunction

    task automatic model_reset();
        m_k      = 0;
        m_load_k = 0;
        m_loaded = 0;
        m_val    = 8'h00;
    endtask

    // One clock: apply inputs, predict registered outputs from the pre-edge model, check #1 after the edge.
    task automatic cycle(input logic ld, input logic [7:0] b, input logic bl);
        logic [6:0] e_seg;
        logic [1:0] e_dig;
        logic       e_busy;
        bit         tens;
        load     = ld;
        bcd_in   = b;
        blank_lz = bl;
        tens  = ((m_k / int'(RD)) % 2) == 1;
        if (model_dark()) begin
            e_seg = 7'h00; e_dig = 2'b00;
        end else if (!tens) begin
            e_seg = seg_tab[m_val[3:0]]; e_dig = 2'b01;
        end else if (bl && m_val[7:4] == 4'd0) begin
            e_seg = 7'h00; e_dig = 2'b00;
        end else begin
            e_seg = seg_tab[m_val[7:4]]; e_dig = 2'b10;
        end
        @(posedge clk);
        #1;
        m_k++;
        if (ld) begin
            m_val    = b;
            m_load_k = m_k;
            m_loaded = 1;
        end
        e_busy = m_loaded && ((m_k - m_load_k) < int'(TOTAL));
        check("seg", {1'b0, seg}, {1'b0, e_seg});
        check("dig_en", {6'd0, dig_en}, {6'd0, e_dig});
        check("busy", {7'd0, busy}, {7'd0, e_busy});
    endtask

    task automatic idle(input int n, input logic bl);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, bl);
    endtask

    // Assert reset between edges, verify immediate clearing, release on the next falling edge.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        load  = 1'b0;
        #1;
        check("rst_seg", {1'b0, seg}, 8'h00);
        check("rst_dig_en", {6'd0, dig_en}, 8'h00);
        check("rst_busy", {7'd0, busy}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        load     = 1'b0;
        bcd_in   = 8'h00;
        blank_lz = 1'b0;
        model_reset();
        #12;
        check("reset_seg", {1'b0, seg}, 8'h00);
        check("reset_dig_en", {6'd0, dig_en}, 8'h00);
        check("reset_busy", {7'd0, busy}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        idle(20, 1'b0);

        cycle(1'b1, 8'h20, 1'b0);
        idle(40, 1'b0);

        cycle(1'b1, 8'h20, 1'b0);
        idle(11, 1'b0);
        cycle(1'b1, 8'h35, 1'b0);
        idle(40, 1'b0);

        cycle(1'b1, 8'h04, 1'b1);
        idle(40, 1'b1);
        cycle(1'b1, 8'h40, 1'b1);
        idle(40, 1'b1);

        cycle(1'b1, 8'h9A, 1'b0);
        idle(40, 1'b0);

        cycle(1'b1, 8'h57, 1'b0);
        idle(10, 1'b0);
        async_reset();
        idle(40, 1'b0);

        for (int i = 0; i < 2500; i++) begin
            logic       ld;
            logic [7:0] b;
            logic       bl;
            ld = ($urandom_range(0, 29) == 0);
            b  = ($urandom_range(0, 3) == 0) ? 8'($urandom) :
                 {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            if ($urandom_range(0, 4) == 0) b[7:4] = 4'd0;
            bl = ($urandom_range(0, 1) == 1);
            cycle(ld, b, bl);
            if ($urandom_range(0, 499) == 0) async_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bcd_display_driver.md
BCD_DISPLAY_DRIVER -- requirements
Module: bcd_display_driver

Interface
REQ-001 Parameter REFRESH_DIV, default 16: clk cycles each digit stays enabled per refresh slot (>=2).
REQ-002 Parameter BLINK_TICKS, default 4096: clk cycles per flash phase (>=1).
REQ-003 Parameter FLASH_COUNT, default 3: dark/lit phase pairs per flash sequence (>=1).
REQ-004 clk  input  1  system clock, 32768 Hz.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 bcd_in  input  8  {tens[7:4], ones[3:0]} value to display.
REQ-007 load  input  1  capture strobe; sampled at posedge clk.
REQ-008 blank_lz  input  1  leading-zero blanking enable for tens digit.
REQ-009 seg  output  7  segment drive, active-high, seg[0]=a ... seg[6]=g.
REQ-010 dig_en  output  2  digit enable, active-high; [0]=ones, [1]=tens; at most one bit high.
REQ-011 busy  output  1  high while a flash sequence runs.

Function
REQ-012 Value register value_q SHALL load bcd_in at any posedge with load=1; display SHALL use value_q only, never bcd_in directly.
REQ-013 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; at wrap the select bit sel SHALL toggle (ones <-> tens).
REQ-014 Decode SHALL be: 0=0x3F 1=0x06 2=0x5B 3=0x4F 4=0x66 5=0x6D 6=0x7D 7=0x07 8=0x7F 9=0x6F; any nibble 10-15 SHALL decode to dash 0x40.
REQ-015 With blank_lz=1 and tens nibble=0, during tens slot dig_en SHALL be 2'b00 and seg 0x00; ones digit is never blanked.
REQ-016 FSM states IDLE, FLASH_DARK, FLASH_LIT; load=1 in any state SHALL enter FLASH_DARK with phase counter and pair counter cleared (load during flash restarts the sequence).
REQ-017 Each flash phase SHALL last exactly BLINK_TICKS cycles; DARK->LIT after one phase; LIT->DARK if fewer than FLASH_COUNT pairs completed, else LIT->IDLE.
REQ-018 In FLASH_DARK dig_en and seg SHALL be 0; in FLASH_LIT and IDLE normal multiplexed display.
REQ-019 busy SHALL be a registered output, high in every cycle after the load edge until the FSM returns to IDLE: total 2*FLASH_COUNT*BLINK_TICKS cycles.
REQ-020 Refresh counter and sel SHALL keep running during flash (dark phases do not stall refresh).
REQ-021 seg and dig_en SHALL be registered: they reflect sel, value_q, state and blank_lz of the previous cycle (1-cycle latency).
REQ-022 Simultaneous load and refresh wrap SHALL both take effect in the same cycle.

Reset
REQ-023 rst_n=0 SHALL asynchronously force value_q=0x00, sel=ones, refresh/phase/pair counters=0, state=IDLE, seg=0x00, dig_en=2'b00, busy=0.
REQ-024 Reset asserted mid-flash SHALL abort the sequence immediately; no flash resumes on release.
REQ-025 First posedge after release SHALL register ones slot of value 0: dig_en=2'b01, seg=0x3F.

Verification (REFRESH_DIV=4, BLINK_TICKS=8, FLASH_COUNT=2)
REQ-026 Reset, blank_lz=0, no load -> dig_en 01 for 4 cycles then 10 for 4, repeating; seg=0x3F in both slots; busy=0.
REQ-027 load with bcd_in=0x20 -> busy high 32 cycles; outputs dark 8, lit 8, dark 8, lit 8; then IDLE: tens slot seg=0x5B, ones slot seg=0x3F.
REQ-028 load 0x20, then load 0x35 at cycle 12 -> flash restarts at dark, busy stays high until 32 cycles after second load; final display tens 0x4F, ones 0x6D.
REQ-029 blank_lz=1, load 0x04, after flash -> tens slot dig_en=00, seg=0x00; ones slot seg=0x66; load 0x40 -> tens 0x66, ones 0x3F (not blanked).
REQ-030 load 0x9A -> tens slot seg=0x6F, ones slot seg=0x40 (dash).
REQ-031 rst_n pulsed low mid-flash between clock edges -> seg=0x00, dig_en=00, busy=0 immediately without a clock edge; after release display shows 0 per REQ-025.
